// File: rtl/dht11_read_scheduler_if.sv
// Host-side command/response channel of the DHT11 read scheduler.
// A transfer happens on a rising clock edge with valid & ready both high; once raised, valid and its payload hold until that edge.
interface dht11_read_scheduler_if;
    logic       req_valid;
    logic [7:0] req_cmd;
    logic       req_ready;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_code;
    logic [7:0] rsp_data;
    logic       busy;

    modport master (
        output req_valid, req_cmd, rsp_ready,
        input  req_ready, rsp_valid, rsp_code, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_cmd, rsp_ready,
        output req_ready, rsp_valid, rsp_code, rsp_data, busy
    );
endinterface

// File: rtl/dht11_read_scheduler.sv
// Turns host commands into DHT11 sensor transactions: read-interval pacing, watchdog,
// checksum check and bounded retries, answering with a code/datum byte pair.
module dht11_read_scheduler #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int MIN_INTERVAL   = 100_000_000,
    parameter int TIMEOUT        = 5_000_000,
    parameter int RELEASE_CYCLES = 200,
    parameter int MAX_RETRIES    = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    dht11_read_scheduler_if.slave      host,
    output logic                       sensor_enable,
    input  logic [39:0]                sensor_data,
    input  logic                       sensor_error,
    input  logic                       sensor_done,
    output logic [2:0]                 fsm_state
);
    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_START, S_WAIT, S_CHECK, S_RELEASE, S_RESPOND
    } state_t;

    localparam int IW = $clog2(MIN_INTERVAL + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(RELEASE_CYCLES + 1);
    localparam int TW = $clog2(MAX_RETRIES + 2);

    localparam logic [IW-1:0] MIN_CNT   = IW'(MIN_INTERVAL);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);
    localparam logic [RW-1:0] REL_LAST  = RW'(RELEASE_CYCLES - 1);
    localparam logic [TW-1:0] RETRY_MAX = TW'(MAX_RETRIES);
    localparam int unused_clk_hz = CLK_HZ;

    state_t        state;
    logic [7:0]    cmd_q;
    logic [TW-1:0] retries;
    logic [IW-1:0] interval;
    logic [WW-1:0] wd;
    logic [RW-1:0] rel_cnt;
    logic [39:0]   data_q;
    logic          err_q;
    logic          timeout_q;
    logic          attempt_ok;
    logic          done_meta;
    logic          done_sync;
    logic [7:0]    sum;

    assign fsm_state = state;
    assign sum = data_q[39:32] + data_q[31:24] + data_q[23:16] + data_q[15:8];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_meta <= 1'b0;
            done_sync <= 1'b0;
        end else begin
            done_meta <= sensor_done;
            done_sync <= done_meta;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            cmd_q         <= 8'h00;
            retries       <= '0;
            interval      <= '0;
            wd            <= '0;
            rel_cnt       <= '0;
            data_q        <= '0;
            err_q         <= 1'b0;
            timeout_q     <= 1'b0;
            attempt_ok    <= 1'b0;
            sensor_enable <= 1'b0;
            host.req_ready <= 1'b0;
            host.rsp_valid <= 1'b0;
            host.rsp_code  <= 8'h00;
            host.rsp_data  <= 8'h00;
            host.busy      <= 1'b0;
        end else begin
            // Saturating; the CHECK branch below clears it as enable falls.
            if (interval != MIN_CNT) interval <= interval + 1'b1;

            case (state)
                S_IDLE: begin
                    host.req_ready <= 1'b1;
                    if (host.req_valid && host.req_ready) begin
                        host.req_ready <= 1'b0;
                        host.busy      <= 1'b1;
                        if (host.req_cmd > 8'h02) begin
                            host.rsp_code  <= 8'hEF;
                            host.rsp_data  <= 8'h00;
                            host.rsp_valid <= 1'b1;
                            state          <= S_RESPOND;
                        end else begin
                            cmd_q   <= host.req_cmd;
                            retries <= '0;
                            state   <= S_GAP;
                        end
                    end
                end

                // Enable is raised on leaving GAP so it is already high in START.
                S_GAP: begin
                    if (interval == MIN_CNT) begin
                        sensor_enable <= 1'b1;
                        wd            <= '0;
                        state         <= S_START;
                    end
                end

                S_START: begin
                    wd    <= wd + 1'b1;
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    wd <= wd + 1'b1;
                    if (done_sync) begin
                        data_q    <= sensor_data;
                        err_q     <= sensor_error;
                        timeout_q <= 1'b0;
                        state     <= S_CHECK;
                    end else if (wd == WD_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    attempt_ok    <= !err_q && !timeout_q && (data_q[7:0] == sum);
                    sensor_enable <= 1'b0;
                    interval      <= '0;
                    rel_cnt       <= '0;
                    state         <= S_RELEASE;
                end

                S_RELEASE: begin
                    if (rel_cnt != REL_LAST) begin
                        rel_cnt <= rel_cnt + 1'b1;
                    end else if (attempt_ok) begin
                        host.rsp_valid <= 1'b1;
                        state          <= S_RESPOND;
                        case (cmd_q)
                            8'h01: begin
                                host.rsp_code <= 8'h09;
                                host.rsp_data <= data_q[23:16];
                            end
                            8'h02: begin
                                host.rsp_code <= 8'h08;
                                host.rsp_data <= data_q[39:32];
                            end
                            default: begin
                                host.rsp_code <= 8'h00;
                                host.rsp_data <= 8'h00;
                            end
                        endcase
                    end else if (retries < RETRY_MAX) begin
                        retries <= retries + 1'b1;
                        state   <= S_GAP;
                    end else begin
                        host.rsp_code  <= 8'h1F;
                        host.rsp_data  <= 8'h00;
                        host.rsp_valid <= 1'b1;
                        state          <= S_RESPOND;
                    end
                end

                S_RESPOND: begin
                    if (host.rsp_ready) begin
                        host.rsp_valid <= 1'b0;
                        host.req_ready <= 1'b1;
                        host.busy      <= 1'b0;
                        state          <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Bench for dht11_read_scheduler: sensor-block model, host driver tasks, reference model
// of retry/checksum outcomes and a response scoreboard.
`timescale 1ns/1ps
module tb_dht11_read_scheduler;
    localparam int MIN_I = 1000;
    localparam int TMO   = 500;
    localparam int REL   = 10;
    localparam int RETR  = 2;

    typedef struct {
        bit         silent;
        int         delay;
        logic [39:0] data;
        bit         err;
    } attempt_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sensor_enable;
    logic [39:0] sensor_data = '0;
    logic        sensor_error = 1'b0;
    logic        sensor_done = 1'b0;
    logic [2:0]  fsm_state;

    dht11_read_scheduler_if host();

    dht11_read_scheduler #(
        .CLK_HZ(50_000_000), .MIN_INTERVAL(MIN_I), .TIMEOUT(TMO),
        .RELEASE_CYCLES(REL), .MAX_RETRIES(RETR)
    ) dut (
        .clock(clock), .reset_n(reset_n), .host(host),
        .sensor_enable(sensor_enable), .sensor_data(sensor_data),
        .sensor_error(sensor_error), .sensor_done(sensor_done),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #900_000;
        $display("FAIL global_timeout cycles=%0d limit=90000", cyc);
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- sensor block model ----------------
    attempt_t plan_q[$];
    int pulses = 0;

    always begin
        attempt_t p;
        @(posedge sensor_enable);
        pulses++;
        if (plan_q.size() > 0) p = plan_q.pop_front();
        else begin
            p.silent = 1; p.delay = 0; p.data = '0; p.err = 0;
        end
        if (!p.silent) begin
            for (int k = 0; k < p.delay && sensor_enable; k++) @(posedge clock);
            if (sensor_enable) begin
                #2;
                sensor_data  = p.data;
                sensor_error = p.err;
                sensor_done  = 1'b1;
            end
        end
        wait (!sensor_enable);
        #3;
        sensor_done = 1'b0;
    end

    // ---------------- enable pulse monitor ----------------
    int   rise_q[$];
    int   fall_q[$];
    int   width_q[$];
    int   last_fall = 0;
    int   rise_cyc = 0;
    logic en_prev = 1'b0;

    always @(negedge clock) begin
        if (sensor_enable && !en_prev) begin
            check("gap_before_rise", (cyc - last_fall) >= MIN_I, 1'b1);
            rise_cyc = cyc;
            rise_q.push_back(cyc);
        end
        if (!sensor_enable && en_prev) begin
            check("enable_high_width", (cyc - rise_cyc) <= TMO + 1, 1'b1);
            last_fall = cyc;
            fall_q.push_back(cyc);
            width_q.push_back(cyc - rise_cyc);
        end
        en_prev = sensor_enable;
        if (!reset_n) last_fall = cyc;
    end

    int n_rsp = 0;
    always @(posedge clock) if (reset_n && host.rsp_valid && host.rsp_ready) n_rsp++;

    // ---------------- reference model ----------------
    attempt_t cur[3];
    logic [15:0] exp_q[$];
    int last_wait = 0;

    function automatic bit good(input attempt_t a);
        int s;
        s = (int'(a.data[39:32]) + int'(a.data[31:24]) + int'(a.data[23:16]) + int'(a.data[15:8])) % 256;
        return !a.silent && (a.delay < TMO - 20) && !a.err && (s == int'(a.data[7:0]));
    endfunction

    function automatic void ref_model(input logic [7:0] cmd, output logic [7:0] code,
                                      output logic [7:0] data, output int np);
        code = 8'h1F; data = 8'h00; np = RETR + 1;
        if (cmd > 8'h02) begin
            code = 8'hEF; np = 0;
            return;
        end
        for (int i = 0; i <= RETR; i++) begin
            if (good(cur[i])) begin
                np = i + 1;
                if (cmd == 8'h01) begin code = 8'h09; data = cur[i].data[23:16]; end
                else if (cmd == 8'h02) begin code = 8'h08; data = cur[i].data[39:32]; end
                else begin code = 8'h00; data = 8'h00; end
                return;
            end
        end
    endfunction

    function automatic attempt_t mk(input bit silent, input int delay, input logic [39:0] data, input bit err);
        attempt_t a;
        a.silent = silent; a.delay = delay; a.data = data; a.err = err;
        return a;
    endfunction

    function automatic attempt_t rand_attempt();
        attempt_t a;
        logic [7:0] h, hd, t, td, cs;
        h = 8'($urandom); hd = 8'($urandom); t = 8'($urandom); td = 8'($urandom);
        cs = h + hd + t + td;
        a.silent = 0; a.err = 0; a.delay = $urandom_range(5, 480);
        case ($urandom_range(0, 7))
            0: a.silent = 1;
            1: a.delay = $urandom_range(520, 700);
            2: a.err = 1;
            3: cs = cs ^ 8'($urandom_range(1, 255));
            default: ;
        endcase
        a.data = {h, hd, t, td, cs};
        return a;
    endfunction

    // ---------------- host driver tasks ----------------
    task automatic send_cmd(input logic [7:0] cmd);
        int n = 0;
        @(negedge clock);
        while (!host.req_ready && n < 20000) begin @(negedge clock); n++; end
        check("req_ready_wait", n < 20000, 1'b1);
        host.req_valid = 1'b1;
        host.req_cmd   = cmd;
        @(posedge clock);
        #1;
        host.req_valid = 1'b0;
    endtask

    task automatic get_rsp(input int hold, output logic [7:0] code, output logic [7:0] data, output int n);
        n = 0;
        while (!host.rsp_valid && n < 20000) begin @(negedge clock); n++; end
        check("rsp_wait", n < 20000, 1'b1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("hold_rsp_valid", host.rsp_valid, 1'b1);
            check("hold_req_ready", host.req_ready, 1'b0);
            check("hold_enable", sensor_enable, 1'b0);
        end
        code = host.rsp_code;
        data = host.rsp_data;
        host.rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        host.rsp_ready = 1'b0;
        @(negedge clock);
        check("rsp_valid_drop", host.rsp_valid, 1'b0);
        check("req_ready_back", host.req_ready, 1'b1);
        check("code_held", host.rsp_code, code);
    endtask

    task automatic run_txn(input logic [7:0] cmd, input int hold, input int strays, input string tag);
        logic [7:0]  ec, ed, code, data;
        logic [15:0] e;
        int ep, p0, r0, n;
        ref_model(cmd, ec, ed, ep);
        exp_q.push_back({ec, ed});
        plan_q.delete();
        for (int i = 0; i < 3; i++) plan_q.push_back(cur[i]);
        p0 = pulses;
        r0 = n_rsp;
        send_cmd(cmd);
        for (int i = 0; i < strays; i++) begin
            @(negedge clock);
            check({tag, "_busy"}, host.busy, 1'b1);
            check({tag, "_ready_low"}, host.req_ready, 1'b0);
            host.req_valid = 1'b1;
            host.req_cmd   = 8'($urandom_range(0, 2));
            @(negedge clock);
            host.req_valid = 1'b0;
        end
        get_rsp(hold, code, data, n);
        e = exp_q.pop_front();
        check({tag, "_code"}, code, e[15:8]);
        check({tag, "_data"}, data, e[7:0]);
        check({tag, "_pulses"}, pulses - p0, ep);
        check({tag, "_one_rsp"}, n_rsp - r0, 1);
        last_wait = n;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n, nr, rel_cyc;
        logic [7:0] cmd;
        host.req_valid = 1'b0;
        host.req_cmd   = 8'h00;
        host.rsp_ready = 1'b0;

        repeat (3) @(negedge clock);
        check("rst_enable", sensor_enable, 1'b0);
        check("rst_rsp_valid", host.rsp_valid, 1'b0);
        check("rst_rsp_code", host.rsp_code, 8'h00);
        check("rst_rsp_data", host.rsp_data, 8'h00);
        check("rst_busy", host.busy, 1'b0);
        check("rst_req_ready", host.req_ready, 1'b0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_req_ready", host.req_ready, 1'b1);
        check("idle_busy", host.busy, 1'b0);

        // temperature read, first after reset
        cur[0] = mk(0, 30, 40'h3C_00_19_00_55, 0);
        cur[1] = mk(1, 0, '0, 0);
        cur[2] = mk(1, 0, '0, 0);
        run_txn(8'h01, 0, 0, "temp");
        check("temp_code_const", host.rsp_code, 8'h09);
        check("temp_data_const", host.rsp_data, 8'h19);

        // humidity after two bad checksums
        cur[0] = mk(0, 40, 40'h3C_00_19_00_54, 0);
        cur[1] = mk(0, 40, 40'h3C_00_19_00_54, 0);
        cur[2] = mk(0, 40, 40'h3C_00_19_00_55, 0);
        run_txn(8'h02, 0, 0, "hum_retry");
        nr = rise_q.size();
        check("hum_rise_spacing1", (rise_q[nr-1] - rise_q[nr-2]) >= MIN_I, 1'b1);
        check("hum_rise_spacing2", (rise_q[nr-2] - rise_q[nr-3]) >= MIN_I, 1'b1);

        // sensor silent: three full-timeout attempts
        for (int i = 0; i < 3; i++) cur[i] = mk(1, 0, '0, 0);
        run_txn(8'h00, 2, 0, "silent");
        for (int i = 1; i <= 3; i++)
            check("silent_width", (width_q[width_q.size()-i] >= TMO) && (width_q[width_q.size()-i] <= TMO + 1), 1'b1);

        // invalid command with response back-pressure
        run_txn(8'h07, 50, 0, "invalid");
        check("invalid_latency", last_wait, 0);

        // back-to-back temperature reads, stray requests while busy
        cur[0] = mk(0, 25, 40'h30_01_17_02_4A, 0);
        run_txn(8'h01, 0, 4, "b2b_first");
        cur[0] = mk(0, 60, 40'h31_00_16_05_4C, 0);
        run_txn(8'h01, 0, 0, "b2b_second");
        check("b2b_gap", (rise_q[rise_q.size()-1] - fall_q[fall_q.size()-2]) >= MIN_I, 1'b1);
        nr = n_rsp;
        repeat (50) @(negedge clock);
        check("no_stray_rsp_valid", host.rsp_valid, 1'b0);
        check("no_stray_rsp_count", n_rsp - nr, 0);

        // reset asserted mid-WAIT
        for (int i = 0; i < 3; i++) cur[i] = mk(1, 0, '0, 0);
        plan_q.delete();
        for (int i = 0; i < 3; i++) plan_q.push_back(cur[i]);
        send_cmd(8'h01);
        n = 0;
        while (!sensor_enable && n < 5000) begin @(negedge clock); n++; end
        check("midrst_enable_seen", sensor_enable, 1'b1);
        repeat (100) @(negedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_enable_drop", sensor_enable, 1'b0);
        check("midrst_rsp_valid", host.rsp_valid, 1'b0);
        check("midrst_busy", host.busy, 1'b0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        rel_cyc = cyc;
        cur[0] = mk(0, 20, 40'h3C_00_19_00_55, 0);
        run_txn(8'h01, 0, 0, "post_reset");
        check("post_reset_wait", (rise_q[rise_q.size()-1] - rel_cyc) >= MIN_I, 1'b1);

        // randomized transactions
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(0, 3);
            cmd = (n == 3) ? 8'($urandom_range(3, 255)) : 8'(n);
            for (int i = 0; i < 3; i++) cur[i] = rand_attempt();
            run_txn(cmd, $urandom_range(0, 5), 0, "rand");
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dht11_read_scheduler.md
# dht11_read_scheduler

Sequencer that owns the DHT11 communication block and turns host commands into sensor transactions. It pulses the sensor block's enable and enforces the DHT11 minimum read interval. It waits for completion with a watchdog, verifies the checksum, retries failed reads, and returns a one-byte code plus one-byte datum to the host side (UART command layer).

## Interface
- CLK_HZ, 50_000_000: `clock` frequency; documentation only.
- MIN_INTERVAL, 100_000_000: cycles required between the end of one sensor transaction and the next enable rise (2 s).
- TIMEOUT, 5_000_000: cycles allowed from enable rise to `sensor_done` (100 ms).
- RELEASE_CYCLES, 200: cycles `sensor_enable` is held low after each transaction (resets the 1 MHz sensor block).
- MAX_RETRIES, 2: extra attempts after a failed read.

Ports:
- `clock` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: host command present.
- `req_cmd` in 8: 0x00 status, 0x01 temperature, 0x02 humidity.
- `req_ready` out 1: high only in IDLE; a command is accepted when `req_valid & req_ready`.
- `rsp_valid` out 1: response present; held until accepted.
- `rsp_ready` in 1: host consumes the response.
- `rsp_code` out 8: 0x00 sensor ok, 0x1F sensor fault, 0x09 temperature, 0x08 humidity, 0xEF invalid command.
- `rsp_data` out 8: integer byte for 0x08/0x09; 0x00 otherwise.
- `busy` out 1: high in every state except IDLE.
- `sensor_enable` out 1: to the sensor block's enable input.
- `sensor_data` in 40: {hum_int, hum_dec, temp_int, temp_dec, checksum}.
- `sensor_error` in 1: sensor block error flag.
- `sensor_done` in 1: sensor block done flag, asynchronous to `clock`; passed through a 2-FF synchronizer before use.

## Operation
- Reset values: `sensor_enable`=0, `rsp_valid`=0, `rsp_code`=0x00, `rsp_data`=0x00, `busy`=0, `req_ready`=0 during reset. FSM=IDLE, retry count 0, interval counter 0. The first read after reset therefore waits the full MIN_INTERVAL, which covers sensor power-up.
- Interval counter: saturating up-counter, cleared on every `sensor_enable` falling edge. "Elapsed" means the count is ≥ MIN_INTERVAL.
- States:
  - **IDLE**: accept a command. An invalid cmd goes to RESPOND with 0xEF and never touches the sensor. A valid cmd latches the cmd, clears retries, and goes to GAP.
  - **GAP**: wait until the interval has elapsed, then go to START.
  - **START**: `sensor_enable`←1, clear the watchdog, go to WAIT.
  - **WAIT**: on synchronized `sensor_done`, latch `sensor_data` and `sensor_error`, then go to CHECK. If the watchdog reaches TIMEOUT, the attempt is marked failed and goes to CHECK. If done and timeout occur in the same cycle, done wins.
  - **CHECK**: the attempt is good when there is no error, no timeout, and byte0 == (byte4+byte3+byte2+byte1) mod 256, computed in 8-bit wraparound. Next state is RELEASE.
  - **RELEASE**: `sensor_enable`←0 for RELEASE_CYCLES.
    - Good attempt: go to RESPOND.
    - Failed attempt with retries < MAX_RETRIES: increment retries and go to GAP.
    - Otherwise: go to RESPOND with 0x1F.
  - **RESPOND**: drive the code and data with `rsp_valid`=1. Leave on `rsp_ready`, then go to IDLE.
- Good-read responses:
  - cmd 0x00 → 0x00/0x00.
  - cmd 0x01 → 0x09/temp_int.
  - cmd 0x02 → 0x08/hum_int.
- `rsp_code` and `rsp_data` hold their last values after `rsp_valid` falls.

## Timing
- Accept-to-enable latency: 2 cycles (IDLE→GAP→START, enable registered) when the interval has already elapsed.
- Done-to-response latency: 2 sync cycles, plus CHECK 1, plus RELEASE_CYCLES, plus 1.
- An invalid command gives `rsp_valid` exactly 1 cycle after acceptance.
- `req_ready` is low from the acceptance cycle +1 until the cycle after the response handshake. `req_valid` while busy is ignored, not queued.
- `sensor_enable` is never high for more than TIMEOUT+1 consecutive cycles. It is never low for fewer than RELEASE_CYCLES between attempts.
- Reset mid-transaction: `sensor_enable` and `rsp_valid` drop asynchronously, and the FSM returns to IDLE with the interval counter cleared.

## Test plan
Bench settings: MIN_INTERVAL=1000, TIMEOUT=500, RELEASE_CYCLES=10, with a sensor-block model.
- **Temperature read:** cmd 0x01, model returns 0x3C_00_19_00_55 → `rsp_code`=0x09, `rsp_data`=0x19, exactly one enable pulse.
- **Humidity read after retries:** cmd 0x02, model returns 0x3C_00_19_00_54 (bad checksum) twice, then good → 0x08/0x3C, three enable pulses each ≥1000 cycles apart.
- **Sensor silent:** cmd 0x00, model never asserts done → three attempts each lasting 500 cycles, then 0x1F/0x00.
- **Invalid command:** cmd 0x07 → 0xEF/0x00 one cycle after acceptance, `sensor_enable` stays 0. Hold `rsp_ready`=0 for 50 cycles: `rsp_valid` stays high and `req_ready` stays low.
- **Back-to-back commands:** two cmd 0x01 back-to-back → second enable rise ≥1000 cycles after the first enable fall. `req_valid` pulses issued while busy produce no response.
- **Reset mid-read:** assert `reset_n`=0 during WAIT → `sensor_enable`=0 the same cycle. After release, next cmd 0x01 waits the full 1000 cycles before enabling.
